// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer: buffers UART RX bytes in a FWFT FIFO and re-emits them as AXI-Stream packets,
// closing a packet after MAX_PKT bytes or once the RX line has been idle for idle_timeout cycles.
module uart_rx_packetizer #(
  parameter int FIFO_AW = 6,
  parameter int MAX_PKT = 64,
  parameter int TO_W    = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               rx_tvalid,
  input  logic [7:0]         rx_tdata,
  input  logic [TO_W-1:0]    idle_timeout,
  input  logic               ovf_clr,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [7:0]         m_tdata,
  output logic               m_tlast,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW = FIFO_AW + 1;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d, rem_q, rem_d;
  logic [16:0]        out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic               flush_q, flush_d, ovf_q, ovf_d;
  logic               hs, wr_en, expire, load;

  always_comb begin
    m_tvalid   = level_q != '0;
    m_tdata    = m_tvalid ? mem[rd_ptr_q] : 8'h00;
    m_tlast    = m_tvalid & ((out_cnt_q == 17'(MAX_PKT - 1)) | (rem_q == LW'(1)));
    fifo_level = level_q;
    overflow   = ovf_q;
    hs         = m_tvalid & m_tready;
    wr_en      = rx_tvalid & (~level_q[FIFO_AW] | hs);
    expire     = ~rx_tvalid && idle_timeout != '0 && idle_cnt_q < idle_timeout &&
                 idle_cnt_q + TO_W'(1) == idle_timeout;
    load       = flush_q & (rem_q == '0);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + FIFO_AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + FIFO_AW'(hs);
    level_d    = level_q + LW'(wr_en) - LW'(hs);
    ovf_d      = (rx_tvalid & ~wr_en) | (ovf_q & ~ovf_clr);
    out_cnt_d  = hs ? (m_tlast ? '0 : out_cnt_q + 17'(1)) : out_cnt_q;
    idle_cnt_d = rx_tvalid ? '0 : (idle_cnt_q < idle_timeout ? idle_cnt_q + TO_W'(1) : idle_cnt_q);
    // A pending flush only claims bytes once the previous boundary has drained
    rem_d      = load ? level_q - LW'(hs) : ((hs && rem_q != '0) ? rem_q - LW'(1) : rem_q);
    flush_d    = (expire & (level_q > rem_q)) | (flush_q & ~load);
  end

  always_ff @(posedge PCLK)
    if (wr_en) mem[wr_ptr_q] <= rx_tdata;

  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rem_q      <= '0;
      out_cnt_q  <= '0;
      idle_cnt_q <= '0;
      flush_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rem_q      <= rem_d;
      out_cnt_q  <= out_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      flush_q    <= flush_d;
      ovf_q      <= ovf_d;
    end
endmodule
